ram_burst_reader: RTL and testbench

//  Read-side controller for the width-converting block RAM. Accepts a burst command
//  (start word address, word count), drives the RAM read address and captures
//  1-cycle-latency read data. Unpacks each RAM word into WIDTH_OUT-bit beats on a

---
 rtl/ram_burst_reader_pkg.sv | 22 ++
 rtl/ram_burst_reader_if.sv | 28 ++
 rtl/ram_burst_reader_unpacker.sv | 77 +++++++
 rtl/ram_burst_reader.sv | 105 ++++++++++
 tb/tb_ram_burst_reader.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_burst_reader_pkg.sv
// ram_burst_pkg: shared FSM state type and width/ratio helpers for the burst reader.
package ram_burst_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    function automatic int ratio(input int width_rd, input int width_out);
        return width_rd / width_out;
    endfunction

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int len_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int beat_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if: command, RAM read port and output stream of the burst reader.
interface ram_burst_reader_if import ram_burst_pkg::*; #(
    parameter int WIDTH_RD  = 16,
    parameter int DEPTH_RD  = 64,
    parameter int WIDTH_OUT = 8
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [addr_w(DEPTH_RD)-1:0] cmd_addr;
    logic [len_w(DEPTH_RD)-1:0]  cmd_len;
    logic [addr_w(DEPTH_RD)-1:0] ram_rd_addr;
    logic [WIDTH_RD-1:0]         ram_rd_data;
    logic                        m_valid;
    logic                        m_ready;
    logic [WIDTH_OUT-1:0]        m_data;
    logic                        m_last;
    logic                        done;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, ram_rd_data, m_ready,
        output cmd_ready, ram_rd_addr, m_valid, m_data, m_last, done
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, ram_rd_data, m_ready,
        input  cmd_ready, ram_rd_addr, m_valid, m_data, m_last, done
    );
endinterface

// File: rtl/ram_burst_reader_unpacker.sv
// ram_word_unpacker: 2-word buffer that splits each RAM word into WIDTH_OUT beats.
// RAM_BURST_LSB_FIRST_EN selects LSB-slice-first order; default is MSB slice first.
module ram_word_unpacker import ram_burst_pkg::*; #(
    parameter int WIDTH_RD  = 16,
    parameter int WIDTH_OUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH_RD-1:0]  i_word,
    input  logic                 i_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH_OUT-1:0] o_data,
    output logic                 o_last,
    output logic [1:0]           o_count,
    output logic                 o_pop
);
    localparam int RATIO = ratio(WIDTH_RD, WIDTH_OUT);
    localparam int BW    = beat_w(RATIO);

    logic [WIDTH_RD-1:0]  r_word [2];
    logic [1:0]           r_last;
    logic                 r_wp;
    logic                 r_rp;
    logic [1:0]           r_cnt;
    logic [BW-1:0]        r_beat;
    logic [WIDTH_RD-1:0]  w_head;
    logic [WIDTH_OUT-1:0] w_slice [RATIO];
    logic                 w_beat_last;
    logic                 w_push;
    logic                 w_fire;

    assign w_head      = r_word[r_rp];
    assign w_beat_last = r_beat == BW'(RATIO - 1);
    assign o_valid     = r_cnt != 2'd0;
    assign o_ready     = r_cnt != 2'd2;
    assign o_count     = r_cnt;
    assign w_push      = i_valid & o_ready;
    assign w_fire      = o_valid & i_ready;
    assign o_pop       = w_fire & w_beat_last;
    assign o_last      = o_valid & w_beat_last & r_last[r_rp];

    for (genvar g = 0; g < RATIO; g++) begin : g_slice
`ifdef RAM_BURST_LSB_FIRST_EN
        assign w_slice[g] = w_head[g*WIDTH_OUT +: WIDTH_OUT];
`else
        assign w_slice[g] = w_head[WIDTH_RD-1-g*WIDTH_OUT -: WIDTH_OUT];
`endif
    end

    // Gate with valid so the idle/reset beat reads as zero.
    assign o_data = o_valid ? w_slice[r_beat] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp   <= 1'b0;
            r_rp   <= 1'b0;
            r_cnt  <= 2'd0;
            r_beat <= '0;
            r_last <= 2'b00;
        end else begin
            if (w_push) begin
                r_last[r_wp] <= i_last;
                r_wp         <= ~r_wp;
            end
            if (w_fire) r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
            if (o_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, o_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_word[r_wp] <= i_word;
    end
endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: burst read controller for the width-converting RAM, streaming beats.
// RAM_BURST_LSB_FIRST_EN (in the unpacker) switches to LSB-slice-first beat order.
module ram_burst_reader import ram_burst_pkg::*; #(
    parameter int WIDTH_RD  = 16,
    parameter int DEPTH_RD  = 64,
    parameter int WIDTH_OUT = 8
) (
    input logic              clk,
    input logic              rst,
    ram_burst_reader_if.slave bus
);
    localparam int AW = addr_w(DEPTH_RD);
    localparam int LW = len_w(DEPTH_RD);

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_left;
    logic          r_req;
    logic          r_req_last;
    logic          r_dat;
    logic          r_dat_last;
    logic          r_done;
    logic          w_hs;
    logic          w_start;
    logic          w_more;
    logic          w_issue;
    logic          w_issue_last;
    logic          w_last_hs;
    logic          w_in_ready;
    logic          w_pop;
    logic [1:0]    w_count;
    logic [2:0]    w_occ;

    assign bus.cmd_ready   = r_state == IDLE;
    assign bus.ram_rd_addr = r_addr;
    assign bus.done        = r_done;

    assign w_hs         = bus.cmd_valid & bus.cmd_ready;
    assign w_start      = w_hs & (bus.cmd_len != '0);
    // Words buffered plus reads in flight, crediting a word freed this cycle.
    assign w_occ        = {1'b0, w_count} + 3'(r_req) + 3'(r_dat) - 3'(w_pop);
    assign w_more       = (r_state == READ) & (r_left != '0) & (w_occ < 3'd2);
    assign w_issue      = w_start | w_more;
    assign w_issue_last = w_start ? (bus.cmd_len == LW'(1)) : (r_left == LW'(1));
    assign w_last_hs    = bus.m_valid & bus.m_ready & bus.m_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_left     <= '0;
            r_req      <= 1'b0;
            r_req_last <= 1'b0;
            r_dat      <= 1'b0;
            r_dat_last <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_req      <= w_issue;
            r_req_last <= w_issue & w_issue_last;
            r_dat      <= r_req;
            r_dat_last <= r_req_last;
            r_done     <= w_last_hs | (w_hs & ~w_start);
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= READ;
                        r_addr  <= bus.cmd_addr;
                        r_left  <= bus.cmd_len - 1'b1;
                    end
                end
                READ: begin
                    if (r_left == '0) begin
                        r_state <= DRAIN;
                    end else if (w_more) begin
                        r_addr <= r_addr + 1'b1;
                        r_left <= r_left - 1'b1;
                        if (r_left == LW'(1)) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_last_hs) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ram_word_unpacker #(
        .WIDTH_RD  (WIDTH_RD),
        .WIDTH_OUT (WIDTH_OUT)
    ) u_unpacker (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_dat & w_in_ready),
        .o_ready (w_in_ready),
        .i_word  (bus.ram_rd_data),
        .i_last  (r_dat_last),
        .o_valid (bus.m_valid),
        .i_ready (bus.m_ready),
        .o_data  (bus.m_data),
        .o_last  (bus.m_last),
        .o_count (w_count),
        .o_pop   (w_pop)
    );
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: randomized bursts checked against a word/beat queue model.
module tb_ram_burst_reader;
    localparam int WIDTH_RD  = 16;
    localparam int DEPTH_RD  = 64;
    localparam int WIDTH_OUT = 8;
    localparam int RATIO     = WIDTH_RD / WIDTH_OUT;
    localparam int AW        = $clog2(DEPTH_RD);
    localparam int LW        = AW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_beats = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    int   ready_mode = 0;

    logic [WIDTH_RD-1:0]  mem [DEPTH_RD];
    logic [WIDTH_OUT-1:0] exp_data [$];
    logic                 exp_last [$];
    logic                 prev_stall = 1'b0;
    logic [WIDTH_OUT-1:0] prev_data = '0;
    logic                 prev_last = 1'b0;

    ram_burst_reader_if #(.WIDTH_RD(WIDTH_RD), .DEPTH_RD(DEPTH_RD), .WIDTH_OUT(WIDTH_OUT)) bus ();

    ram_burst_reader #(.WIDTH_RD(WIDTH_RD), .DEPTH_RD(DEPTH_RD), .WIDTH_OUT(WIDTH_OUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) bus.ram_rd_data <= mem[bus.ram_rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected beats: each word split into RATIO slices in the configured order.
    function automatic void model_burst(input int addr, input int len);
        for (int w = 0; w < len; w++) begin
            logic [WIDTH_RD-1:0] word;
            word = mem[(addr + w) % DEPTH_RD];
            for (int k = 0; k < RATIO; k++) begin
`ifdef RAM_BURST_LSB_FIRST_EN
                exp_data.push_back(WIDTH_OUT'(word >> (k * WIDTH_OUT)));
`else
                exp_data.push_back(WIDTH_OUT'(word >> (WIDTH_RD - (k + 1) * WIDTH_OUT)));
`endif
                exp_last.push_back(w == len - 1 && k == RATIO - 1);
            end
        end
    endfunction

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", bus.m_valid, 1);
                check("hold_data", bus.m_data, prev_data);
                check("hold_last", bus.m_last, prev_last);
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_data.size() == 0) begin
                    check("extra_beat", bus.m_valid & bus.m_ready, 0);
                end else begin
                    check("beat_data", bus.m_data, exp_data.pop_front());
                    check("beat_last", bus.m_last, exp_last.pop_front());
                end
                if (n_beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_beats++;
            end
            prev_stall = bus.m_valid & ~bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    task automatic run_burst(input int addr, input int len, input int mode);
        int c0;
        int done_cyc;
        ready_mode = mode;
        n_beats    = 0;
        model_burst(addr, len);
        @(posedge clk);
        #1;
        check("idle_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = AW'(addr);
        bus.cmd_len   = LW'(len);
        c0 = cyc;
        @(posedge clk);
        #1;
        check("busy_cmd_ready", bus.cmd_ready, len == 0);
        if (len != 0) begin
            check("first_rd_addr", bus.ram_rd_addr, addr);
            bus.cmd_addr = AW'($urandom);
            bus.cmd_len  = LW'($urandom);
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        done_cyc = -1;
        for (int i = 0; i < 2000 && done_cyc < 0; i++) begin
            @(negedge clk);
            if (bus.done) done_cyc = cyc;
        end
        check("done_seen", done_cyc >= 0, 1);
        check("done_cmd_ready", bus.cmd_ready, 1);
        if (len == 0) begin
            check("len0_done_cycle", done_cyc - c0, 1);
            check("len0_beats", n_beats, 0);
        end else begin
            check("done_after_last", done_cyc - last_cyc, 1);
            check("beat_count", n_beats, len * RATIO);
            if (mode == 0) begin
                check("first_latency", first_cyc - c0, 3);
                check("no_bubbles", last_cyc - first_cyc, len * RATIO - 1);
            end
        end
        check("queue_drained", exp_data.size(), 0);
        @(negedge clk);
        check("done_pulse", bus.done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH_RD; i++) mem[i] = 16'hA000 + WIDTH_RD'(i);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        #3;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_done", bus.done, 0);
        check("rst_rd_addr", bus.ram_rd_addr, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;

        run_burst(5, 2, 0);
        run_burst(62, 4, 0);
        run_burst(0, 8, 1);
        run_burst(0, 8, 2);
        run_burst(0, 0, 0);
        run_burst(5, 1, 0);
        run_burst(33, 64, 2);
        run_burst(17, 64, 0);

        // Reset in the middle of a burst, with reads still in flight.
        ready_mode = 0;
        n_beats    = 0;
        model_burst(0, 8);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = '0;
        bus.cmd_len   = LW'(8);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 100 && n_beats < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_beats", n_beats, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_ready", bus.cmd_ready, 1);
        check("mid_rst_m_valid", bus.m_valid, 0);
        check("mid_rst_m_data", bus.m_data, 0);
        check("mid_rst_m_last", bus.m_last, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_rd_addr", bus.ram_rd_addr, 0);
        exp_data.delete();
        exp_last.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        run_burst(10, 1, 0);

        for (int t = 0; t < 25; t++)
            run_burst(int'($urandom_range(0, DEPTH_RD - 1)), int'($urandom_range(0, 12)), int'($urandom_range(0, 2)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
